// File: rtl/fir_sequencer_if.sv
// fir_sequencer_if: sample stream, result stream and coefficient port
// of the time-multiplexed FIR sequencer.
interface fir_sequencer_if #(
  parameter int NUM_TAPS = 3
) ();
  localparam int KW = $clog2(NUM_TAPS);

  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              coef_wr_en;
  logic [KW-1:0]     coef_wr_addr;
  logic signed [7:0] coef_wr_data;
  logic              busy;

  modport master (
    output in_data, in_valid, out_ready,
    output coef_wr_en, coef_wr_addr, coef_wr_data,
    input  in_ready, out_data, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    input  coef_wr_en, coef_wr_addr, coef_wr_data,
    output in_ready, out_data, out_valid, busy
  );
endinterface

// File: rtl/fir_sequencer.sv
// fir_sequencer: one shared 8x8 MAC sequenced across NUM_TAPS taps.
// Define FIR_SEQUENCER_ROUND_EN for round-half-up instead of floor.
module fir_sequencer #(
  parameter int NUM_TAPS = 3
) (
  input logic            clk,
  input logic            rst,
  fir_sequencer_if.slave bus
);
  localparam int KW = $clog2(NUM_TAPS);
  localparam int AW = 16 + KW;
  localparam logic [KW:0]   NT    = (KW+1)'(NUM_TAPS);
  localparam logic [KW-1:0] KLAST = KW'(NUM_TAPS - 1);
  localparam logic signed [AW-1:0] SMAX = AW'(127);
  localparam logic signed [AW-1:0] SMIN = AW'(-128);
  localparam logic signed [AW-1:0] RND  = AW'(64);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_OUT
  } state_t;

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [KW-1:0]         r_wptr;
  logic signed [7:0]     r_x    [NUM_TAPS];
  logic signed [7:0]     r_coef [NUM_TAPS];
  logic signed [AW-1:0]  r_acc;
  logic signed [7:0]     r_out_data;
  logic                  r_out_valid;
  logic                  r_in_ready;
  logic                  r_busy;

  logic [KW-1:0]         w_idx;
  logic signed [15:0]    w_prod;
  logic signed [AW-1:0]  w_sum;
  logic signed [AW-1:0]  w_rnd;
  logic signed [AW-1:0]  w_sh;
  logic signed [7:0]     w_sat;
  logic                  w_wr_ok;
  logic                  w_accept;

  // x[n-k] lives k slots behind the write pointer, modulo NUM_TAPS
  always_comb begin
    w_idx = '0;
    if ({1'b0, r_k} <= {1'b0, r_wptr})
      w_idx = r_wptr - r_k;
    else
      w_idx = KW'({1'b0, r_wptr} + NT - {1'b0, r_k});
  end

  assign w_prod = r_coef[r_k] * r_x[w_idx];
  assign w_sum  = r_acc + {{(AW-16){w_prod[15]}}, w_prod};

`ifdef FIR_SEQUENCER_ROUND_EN
  assign w_rnd = w_sum + RND;
`else
  assign w_rnd = w_sum;
`endif

  assign w_sh = w_rnd >>> 7;

  always_comb begin
    w_sat = w_sh[7:0];
    if (w_sh > SMAX)
      w_sat = 8'sh7f;
    else if (w_sh < SMIN)
      w_sat = -8'sd128;
  end

  assign w_wr_ok = bus.coef_wr_en && !r_busy &&
                   ({1'b0, bus.coef_wr_addr} < NT);
  assign w_accept = (r_state == S_IDLE) &&
                    bus.in_valid && r_in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_wptr      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        r_x[i]    <= '0;
        r_coef[i] <= '0;
      end
    end else begin
      if (w_wr_ok)
        r_coef[bus.coef_wr_addr] <= bus.coef_wr_data;
      unique case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_x[r_wptr] <= bus.in_data;
            r_acc       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
          if (r_k == KLAST) begin
            r_out_data  <= w_sat;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_wptr      <= (r_wptr == KLAST) ? '0 : r_wptr + 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed steps with a scoreboard queue of expected
// outputs, checked by immediate assertions.
module tb_fir_sequencer;
`ifdef FIR_SEQUENCER_ROUND_EN
  localparam int RND = 64;
`else
  localparam int RND = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_sequencer_if #(.NUM_TAPS(3)) bus ();

  fir_sequencer #(.NUM_TAPS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q [$];
  int lat_q [$];
  int thr_q [$];
  int hist  [$];
  int sh [3];
  bit chk_lat = 1'b0;
  int mon_t;
  logic signed [7:0] held;

  always @(posedge clk) cyc++;

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model();
    int acc = 0;
    for (int k = 0; k < 3; k++)
      if (k < hist.size()) acc += sh[k] * hist[k];
    acc = (acc + RND) >>> 7;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic send(input logic signed [7:0] x,
                      input bit use_e, input int e);
    bit ok = 1'b0;
    bus.in_data  = x;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      hist.push_front(int'(x));
      if (hist.size() > 3) void'(hist.pop_back());
      exp_q.push_back(use_e ? e : model());
      lat_q.push_back(cyc + 1);
      thr_q.push_back(cyc + 1);
    end else begin
      check("send_timeout", bus.in_ready, 1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wcoef(input logic [1:0] a,
                       input logic signed [7:0] d, input bit apply);
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = a;
    bus.coef_wr_data = d;
    @(posedge clk); #1;
    bus.coef_wr_en = 1'b0;
    if (apply) sh[a] = int'(d);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      check("out_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0)
        check("out_data", bus.out_data, exp_q.pop_front());
      if (lat_q.size() > 0) begin
        mon_t = lat_q.pop_front();
        if (chk_lat) check("latency", cyc + 1 - mon_t, 4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid     = 1'b1;
    bus.in_data      = 8'sd127;
    bus.out_ready    = 1'b0;
    bus.coef_wr_en   = 1'b0;
    bus.coef_wr_addr = '0;
    bus.coef_wr_data = '0;
    sh = '{0, 0, 0};

    // reset held with a valid sample pending
    repeat (5) begin
      @(posedge clk); #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_data", bus.out_data, 0);
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_busy", bus.busy, 0);

    // impulse response
    wcoef(2'd0, 8'sd64, 1'b1);
    wcoef(2'd1, 8'sd32, 1'b1);
    wcoef(2'd2, -8'sd16, 1'b1);
    bus.out_ready = 1'b1;
    chk_lat = 1'b1;
    send(8'sd127, 1'b1, 63 + RND / 64);
    send(8'sd0, 1'b1, 31 + RND / 64);
    send(8'sd0, 1'b1, -16);
    drain();
    chk_lat = 1'b0;

    // DC gain, then saturation both ways
    send(8'sd127, 1'b1, 63 + RND / 64);
    send(8'sd127, 1'b1, 95);
    send(8'sd127, 1'b1, 79);
    send(8'sd127, 1'b1, 79);
    drain();
    wcoef(2'd0, 8'sd127, 1'b1);
    wcoef(2'd1, 8'sd127, 1'b1);
    wcoef(2'd2, 8'sd127, 1'b1);
    repeat (3) send(8'sd127, 1'b1, 127);
    send(-8'sd128, 1'b0, 0);
    send(-8'sd128, 1'b0, 0);
    send(-8'sd128, 1'b1, -128);
    drain();

    // backpressure holds OUT
    wcoef(2'd0, 8'sd16, 1'b1);
    wcoef(2'd1, -8'sd8, 1'b1);
    wcoef(2'd2, 8'sd4, 1'b1);
    bus.out_ready = 1'b0;
    send(8'sd100, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid === 1'b1) break;
      @(posedge clk); #1;
    end
    check("bp_reach_out", bus.out_valid, 1);
    held = bus.out_data;
    repeat (10) begin
      @(negedge clk);
      check("bp_hold", bus.out_data, held);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.out_valid, 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // continuous input: one accept every five cycles
    thr_q.delete();
    send(-8'sd50, 1'b0, 0);
    send(8'sd77, 1'b0, 0);
    send(8'sd3, 1'b0, 0);
    send(-8'sd128, 1'b0, 0);
    drain();
    check("thr_count", thr_q.size(), 4);
    for (int i = 0; i + 1 < thr_q.size(); i++)
      check("thr_period", thr_q[i+1] - thr_q[i], 5);

    // write while busy is dropped
    send(8'sd40, 1'b0, 0);
    check("busy_during_mac", bus.busy, 1);
    wcoef(2'd0, 8'sd100, 1'b0);
    drain();
    send(8'sd90, 1'b0, 0);
    send(-8'sd70, 1'b0, 0);
    drain();

    // out-of-range address is ignored
    wcoef(2'd3, 8'sd99, 1'b0);
    send(8'sd120, 1'b0, 0);
    send(8'sd120, 1'b0, 0);
    drain();

    // write coincident with accept applies to that sample
    bus.coef_wr_en   = 1'b1;
    bus.coef_wr_addr = 2'd0;
    bus.coef_wr_data = -8'sd64;
    sh[0] = -64;
    send(8'sd50, 1'b0, 0);
    bus.coef_wr_en = 1'b0;
    drain();

    // reset in the middle of MAC
    send(8'sd100, 1'b0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    lat_q.delete();
    hist.delete();
    sh = '{0, 0, 0};
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_out_data", bus.out_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rel_in_ready", bus.in_ready, 1);
    wcoef(2'd0, 8'sd64, 1'b1);
    wcoef(2'd1, 8'sd32, 1'b1);
    wcoef(2'd2, -8'sd16, 1'b1);
    send(8'sd127, 1'b1, 63 + RND / 64);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
